psubsb_seq: RTL

- Multi-cycle packed saturating subtract unit (PSUBSB) for the execute stage. Computes Diff = A − B independently on each signed 4-bit lane of a 16-bit word.
- Handles one lane per cycle through a single shared lane subtractor. Start/done handshake.
- Pairs with the packed saturating add unit: same lane layout and saturation limits, opposite operation.

---
 rtl/psubsb_pkg.sv | 19 +
 rtl/nibble_subsat.sv | 32 +++
 rtl/psubsb_seq.sv | 130 +++++++++++++
 3 files changed

// File: rtl/psubsb_pkg.sv
// Shared constants and FSM state type for the packed saturating subtract unit.
// Lane layout and saturation limits match the packed saturating add unit.
package psubsb_pkg;

    localparam int LANE_W = 4;
    localparam int LANES  = 4;
    localparam int DATA_W = LANE_W * LANES;
    localparam int CNT_W  = $clog2(LANES);

    localparam logic [LANE_W-1:0] LANE_MAX = {1'b0, {(LANE_W-1){1'b1}}};
    localparam logic [LANE_W-1:0] LANE_MIN = {1'b1, {(LANE_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_subsat.sv
// Combinational signed saturating subtractor for a single lane: diff = a - b,
// clamped to the lane's signed range; sat flags a clamp.
module nibble_subsat
    import psubsb_pkg::*;
(
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    output logic [LANE_W-1:0] diff,
    output logic              sat
);

    logic [LANE_W-1:0] w_raw;
    logic              w_pos_ovf;
    logic              w_neg_ovf;

    // Two's complement subtract; the carry out of the lane is dropped.
    assign w_raw     = a + ~b + LANE_W'(1);
    assign w_pos_ovf = ~a[LANE_W-1] &  b[LANE_W-1] &  w_raw[LANE_W-1];
    assign w_neg_ovf =  a[LANE_W-1] & ~b[LANE_W-1] & ~w_raw[LANE_W-1];

    always_comb begin
        diff = w_raw;
        if (w_pos_ovf) begin
            diff = LANE_MAX;
        end else if (w_neg_ovf) begin
            diff = LANE_MIN;
        end
    end

    assign sat = w_pos_ovf | w_neg_ovf;

endmodule

// File: rtl/psubsb_seq.sv
// Multi-cycle packed saturating subtract: one lane per cycle through a shared
// lane subtractor. Optional per-lane saturation flags under PSUBSB_SATFLAG_EN.
module psubsb_seq
    import psubsb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] Diff,
`ifdef PSUBSB_SATFLAG_EN
    output logic [LANES-1:0]  sat_flags,
`endif
    output logic [1:0]        o_dbg_state
);

    state_t              r_state;
    state_t              w_next_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [DATA_W-1:0]   r_shadow;
    logic [DATA_W-1:0]   r_diff;
    logic [DATA_W-1:0]   w_shadow_upd;
    logic [LANE_W-1:0]   w_lane_a;
    logic [LANE_W-1:0]   w_lane_b;
    logic [LANE_W-1:0]   w_lane_diff;
    logic                w_lane_sat;
    logic                w_last_lane;

    assign w_lane_a    = r_a[int'(r_cnt)*LANE_W +: LANE_W];
    assign w_lane_b    = r_b[int'(r_cnt)*LANE_W +: LANE_W];
    assign w_last_lane = (r_cnt == CNT_W'(LANES-1));

    nibble_subsat u_lane (
        .a    (w_lane_a),
        .b    (w_lane_b),
        .diff (w_lane_diff),
        .sat  (w_lane_sat)
    );

    // Shadow with the current lane merged in; the last lane's merge is what
    // gets published, so Diff never shows a partial result.
    always_comb begin
        w_shadow_upd = r_shadow;
        w_shadow_upd[int'(r_cnt)*LANE_W +: LANE_W] = w_lane_diff;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: if (start) w_next_state = CALC;
            CALC: if (w_last_lane) w_next_state = FIN;
            FIN:  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_shadow <= '0;
            r_diff   <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a      <= A;
                        r_b      <= B;
                        r_shadow <= '0;
                        r_cnt    <= '0;
                    end
                end
                CALC: begin
                    r_shadow <= w_shadow_upd;
                    if (w_last_lane) begin
                        r_diff <= w_shadow_upd;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef PSUBSB_SATFLAG_EN
    logic [LANES-1:0] r_sat_shadow;
    logic [LANES-1:0] r_sat_flags;
    logic [LANES-1:0] w_sat_upd;

    always_comb begin
        w_sat_upd = r_sat_shadow;
        w_sat_upd[r_cnt] = w_lane_sat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sat_shadow <= '0;
            r_sat_flags  <= '0;
        end else if (r_state == IDLE && start) begin
            r_sat_shadow <= '0;
        end else if (r_state == CALC) begin
            r_sat_shadow <= w_sat_upd;
            if (w_last_lane) begin
                r_sat_flags <= w_sat_upd;
            end
        end
    end

    assign sat_flags = r_sat_flags;
`else
    logic w_unused_sat;
    assign w_unused_sat = w_lane_sat;
`endif

    assign busy        = (r_state == CALC);
    assign done        = (r_state == FIN);
    assign Diff        = r_diff;
    assign o_dbg_state = r_state;

endmodule
